// File: rtl/i2c_slave_prog.sv
// i2c_slave_prog: I2C target that writes and reads back a byte-wide memory.
//   clk, rst_n      : system clock, synchronous active-low reset
//   scl_in, sda_in  : raw bus pins, oversampled on clk
//   sda_oe          : 1 pulls SDA low (open-drain)
//   wr_en/addr/data : single-clk write strobe to memory
//   rd_addr/rd_data : read port, rd_addr always equals the pointer
//   busy            : addressed transaction in progress
module i2c_slave_prog #(
    parameter logic [6:0] DEVICE_ADDR = 7'h2A,
    parameter int         PTR_W       = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [7:0]             byte_in;
    logic [PTR_W-1:0]       ptr;
    logic                   rw, ack_on, mack, inc_pend;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SDA edges only count as START/STOP while SCL is steadily high
    assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;
    assign byte_in   = {shreg[6:0], sda_s};
    assign rd_addr   = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            ack_on   <= 1'b0;
            mack     <= 1'b0;
            inc_pend <= 1'b0;
            sda_oe   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            wr_en    <= 1'b0;

            // pointer advance is deferred one clk so wr_addr carries the old value
            if (inc_pend) begin
                ptr      <= ptr + PTR_W'(1);
                inc_pend <= 1'b0;
            end

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == ADDR) begin
                                rw    <= sda_s;
                                state <= (byte_in[7:1] == DEVICE_ADDR) ? ADDR_ACK : WAIT;
                            end else if (state == PTR) begin
                                ptr   <= byte_in[PTR_W-1:0];
                                state <= PTR_ACK;
                            end else begin
                                wr_en    <= 1'b1;
                                wr_addr  <= ptr;
                                wr_data  <= byte_in;
                                inc_pend <= 1'b1;
                                state    <= WDATA_ACK;
                            end
                        end
                    end
                    // first fall (end of bit 8) asserts ACK, second fall (end of bit 9) releases
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            sda_oe <= 1'b1;
                            ack_on <= 1'b1;
                            if (state == ADDR_ACK) busy <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw) begin
                                shreg  <= rd_data;
                                sda_oe <= ~rd_data[7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    // shift on rise so shreg[7] holds the bit to drive at the next fall
                    RDATA: if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            mack   <= 1'b0;
                            state  <= RDATA_ACK;
                        end else begin
                            sda_oe <= ~shreg[7];
                        end
                    end
                    RDATA_ACK: if (scl_rise) begin
                        inc_pend <= 1'b1;
                        mack     <= ~sda_s;
                        if (sda_s) state <= WAIT;
                    end else if (scl_fall && mack) begin
                        mack    <= 1'b0;
                        bit_cnt <= '0;
                        shreg   <= rd_data;
                        sda_oe  <= ~rd_data[7];
                        state   <= RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_prog.sv
module tb_i2c_slave_prog;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, scl, sda_m;
    logic       sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       sda_oe4, wr_en4, busy4;
    logic [3:0] wr_addr4, rd_addr4;
    logic [7:0] wr_data4;
    logic [7:0] mem [256];
    wire        sda_line = sda_m & ~sda_oe & ~sda_oe4;

    int          checks = 0, fails = 0;
    logic [15:0] wr_q[$];
    logic [11:0] wr4_q[$];
    logic [7:0]  rd_q[$];
    logic [15:0] wr_exp;
    logic [11:0] wr4_exp;
    logic        wr_prev = 1'b0, wr4_prev = 1'b0;
    logic        oe_seen = 1'b0, busy_seen = 1'b0;

    assign rd_data = mem[rd_addr];

    i2c_slave_prog #(.DEVICE_ADDR(7'h2A), .PTR_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy)
    );

    i2c_slave_prog #(.DEVICE_ADDR(7'h33), .PTR_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .rd_addr(rd_addr4),
        .rd_data(8'h00), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // write scoreboards: expectations pushed when data bytes are driven
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_pulse", wr_prev, 0);
            if (wr_q.size() == 0) check("wr_unexp", 1, 0);
            else begin
                wr_exp = wr_q.pop_front();
                check("wr_addr", wr_addr, wr_exp[15:8]);
                check("wr_data", wr_data, wr_exp[7:0]);
            end
        end
        if (wr_en4) begin
            check("wr4_pulse", wr4_prev, 0);
            if (wr4_q.size() == 0) check("wr4_unexp", 1, 0);
            else begin
                wr4_exp = wr4_q.pop_front();
                check("wr4_addr", wr_addr4, wr4_exp[11:8]);
                check("wr4_data", wr_data4, wr4_exp[7:0]);
            end
        end
        wr_prev  = wr_en;
        wr4_prev = wr_en4;
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
    end

    task automatic q();
        repeat (10) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl = 1'b1;   q();
        sda_m = 1'b0; q();
        scl = 1'b0;   q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl = 1'b1;   q();
        sda_m = 1'b1; q();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;  q();
        scl = 1'b1; q();
        #1 s = sda_line;
        q();
        scl = 1'b0; q();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic ack_m, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~ack_m, s);
    endtask

    logic       ack, s;
    logic [7:0] d;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h50] = 8'h00;
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_oe", sda_oe, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ptr", rd_addr, 0);
        rst_n = 1'b1;
        q();

        // plain write of two bytes
        i2c_start();
        wr_byte(8'h54, ack); check("w_addr_ack", ack, 1);
        check("w_busy", busy, 1);
        wr_byte(8'h10, ack); check("w_ptr_ack", ack, 1);
        wr_q.push_back({8'h10, 8'hA5});
        wr_byte(8'hA5, ack); check("w_d0_ack", ack, 1);
        wr_q.push_back({8'h11, 8'h3C});
        wr_byte(8'h3C, ack); check("w_d1_ack", ack, 1);
        i2c_stop(); q();
        check("w_busy_off", busy, 0);
        check("w_ptr_end", rd_addr, 8'h12);

        // read back through a repeated START
        i2c_start();
        wr_byte(8'h54, ack); check("r_addr_ack", ack, 1);
        wr_byte(8'h20, ack); check("r_ptr_ack", ack, 1);
        i2c_start();
        wr_byte(8'h55, ack); check("r_addr2_ack", ack, 1);
        rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
        for (int i = 0; i < 3; i++) begin
            rd_byte(i != 2, d);
            check("r_data", d, rd_q.pop_front());
        end
        i2c_stop(); q();
        check("r_ptr_end", rd_addr, 8'h23);

        // wrong address: never driven, never busy
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        wr_byte(8'h56, ack); check("m_addr_nack", ack, 0);
        wr_byte(8'h00, ack); check("m_d_nack", ack, 0);
        i2c_stop(); q();
        check("m_oe_seen", oe_seen, 0);
        check("m_busy_seen", busy_seen, 0);

        // STOP inside a data byte, then a normal write
        i2c_start();
        wr_byte(8'h54, ack);
        wr_byte(8'h40, ack); check("a_ptr_ack", ack, 1);
        for (int i = 0; i < 5; i++) clk_bit(1'b1, s);
        i2c_stop(); q();
        check("a_oe", sda_oe, 0);
        check("a_busy", busy, 0);
        check("a_ptr", rd_addr, 8'h40);
        i2c_start();
        wr_byte(8'h54, ack); check("a2_addr_ack", ack, 1);
        wr_byte(8'h41, ack); check("a2_ptr_ack", ack, 1);
        wr_q.push_back({8'h41, 8'h77});
        wr_byte(8'h77, ack); check("a2_d_ack", ack, 1);
        i2c_stop(); q();

        // 4-bit pointer wraps 0xF -> 0x0
        i2c_start();
        wr_byte(8'h66, ack); check("p4_addr_ack", ack, 1);
        wr_byte(8'h0F, ack); check("p4_ptr_ack", ack, 1);
        wr4_q.push_back({4'hF, 8'hAA});
        wr_byte(8'hAA, ack);
        wr4_q.push_back({4'h0, 8'hBB});
        wr_byte(8'hBB, ack); check("p4_d1_ack", ack, 1);
        i2c_stop(); q();
        check("p4_ptr_end", rd_addr4, 4'h1);

        // reset while the target is driving a 0 bit
        i2c_start();
        wr_byte(8'h54, ack);
        wr_byte(8'h50, ack);
        i2c_start();
        wr_byte(8'h55, ack); check("x_addr_ack", ack, 1);
        check("x_drive0", sda_oe, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("x_oe", sda_oe, 0);
        check("x_busy", busy, 0);
        check("x_ptr", rd_addr, 0);
        check("x_wr_addr", wr_addr, 0);
        check("x_wr_data", wr_data, 0);
        rst_n = 1'b1;
        i2c_stop(); q();

        check("wr_q_empty", wr_q.size(), 0);
        check("wr4_q_empty", wr4_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/i2c_slave_prog.md
Name: i2c_slave_prog

Overview:
- Parametrised I2C target that programs and reads back an external byte-wide memory such as processor program RAM.
- Oversamples SCL/SDA on the system clock. Decodes START, STOP and repeated START.
- Matches a configurable 7-bit device address and keeps an auto-incrementing pointer.
- Issues single-cycle write strobes and fetches read-back bytes from the memory. Successor to the fixed single-purpose programming port, with read support, address matching and parametrised pointer width.

Parameters:
DEVICE_ADDR, 7'h2A, 7-bit I2C address this target ACKs
PTR_W, 8, pointer/memory address width (1..8); pointer wraps modulo 2^PTR_W
SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in (>=2)

Ports:
clk      input   1       system clock; must be >= 10x SCL frequency
rst_n    input   1       reset, synchronous, active-low
scl_in   input   1       raw SCL pin
sda_in   input   1       raw SDA pin
sda_oe   output  1       1 = pull SDA low (open-drain); 0 = release
wr_en    output  1       one-clk write strobe to memory
wr_addr  output  PTR_W   write address, valid with wr_en
wr_data  output  8       write data, valid with wr_en
rd_addr  output  PTR_W   read address; always equals current pointer
rd_data  input   8       memory data for rd_addr; combinational or registered memory; must be stable 2 clk after rd_addr changes
busy     output  1       high from address ACK until STOP or next START

Behaviour:
- Clock and reset: single clock domain (clk). rst_n is synchronous, active-low.
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0, state IDLE, sync flops=1. Reset mid-transfer releases SDA on the next clk edge.
- Input path: SYNC_STAGES flops, then one edge register. An event is seen SYNC_STAGES+1 clk after the pin change.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- Bit timing: data is sampled on the detected SCL rising edge. sda_oe changes only on the detected SCL falling edge, except on STOP, START or reset, which release it immediately.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
  - START from any state -> ADDR, bit counter cleared, sda_oe=0.
  - STOP from any state -> IDLE, busy=0, sda_oe=0.
  - ADDR: shift 8 bits, MSB first. On match of bits[7:1] with DEVICE_ADDR -> ADDR_ACK, drive ACK for the 9th clock, busy=1. Mismatch -> WAIT; no ACK, SDA never driven.
  - After ADDR_ACK: R/W=0 -> PTR. R/W=1 -> RDATA, loading the shift register from rd_data at the ACK-ending SCL fall.
  - PTR: 8 bits received. Pointer <= byte[PTR_W-1:0]. ACK -> WDATA.
  - WDATA: on the 8th bit sample, wr_en=1 for exactly one clk with wr_addr=pointer and wr_data=byte. Pointer increments in the following clk. ACK -> WDATA.
  - RDATA: drive the inverse of each bit (oe=1 for a 0 bit), MSB first, then release for the 9th clock.
    - Master ACK (SDA low at 9th rise): pointer++, next byte loaded from rd_data at the following SCL fall.
    - Master NACK: -> WAIT. Pointer is still incremented.
  - WAIT: ignore everything until START or STOP.
- Pointer: wraps from 2^PTR_W-1 to 0. Persists across transactions; cleared only by reset.
- Address 7'h00 (general call) is NACKed unless DEVICE_ADDR=0. 10-bit addressing and clock stretching are not supported.
- START or STOP inside a byte aborts that byte. No wr_en is issued for a partial byte.

Test Plan:
- Write: START, 0x54 (addr 0x2A W), 0x10, 0xA5, 0x3C, STOP -> ACK on all 4 bytes; wr_en pulses twice, (0x10,0xA5) then (0x11,0x3C); busy drops at STOP.
- Read via repeated START: START 0x54 0x20, Sr 0x55, read 3 bytes (ACK,ACK,NACK) with mem[0x20..0x22]=0x11,0x22,0x33 -> SDA returns 0x11,0x22,0x33; pointer ends at 0x23; no wr_en.
- Address mismatch: START 0x56, 0x00, STOP -> sda_oe never asserted, no wr_en, busy stays 0.
- Wrap, PTR_W=4: pointer 0x0F, write 0xAA, 0xBB -> writes at 0xF then 0x0.
- Abort: STOP after 5 bits of a data byte -> no wr_en, sda_oe=0, state IDLE. Next write transaction is ACKed normally.
- Reset mid-read: assert rst_n=0 while driving a 0 bit -> sda_oe=0 the next clk, pointer=0, all outputs at reset values.
